dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-memory port of `main_mem` between the CPU load/store unit and the program loader/debug master. It formats byte/half/word stores into lane enables, and aligns and extends load data. It honours `main_mem` back-pressure and sequences `fence_i` requests into an instruction-memory sync. It sits between the core's memory stage, the loader, and `main_mem`'s `i_dm_*`/`i_fence_i`/`o_ready` pins.

## Interface
- `STARVE_LIMIT`, default 4: maximum number of consecutive CPU grants while the loader is waiting; after that the loader wins one slot.
- `i_clk`  in  1  rising-edge clock; single clock domain.
- `i_rst_n`  in  1  synchronous, active-low reset.
- `i_cpu_req`, `i_cpu_we`  in  1  CPU access request, write flag.
- `i_cpu_size`  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned.
- `i_cpu_unsigned`  in  1  zero-extend loads (LBU/LHU).
- `i_cpu_addr`  in  16  byte address.
- `i_cpu_wdata`  in  32  store data, right-justified.
- `i_cpu_fence_i`  in  1  single-cycle pulse; requests an IM sync.
- `o_cpu_gnt`  out  1  CPU request accepted this cycle.
- `o_cpu_misaligned`  out  1  pulses together with `o_cpu_gnt` when the access is rejected as misaligned.
- `o_cpu_rvalid`  out  1  load data valid.
- `o_cpu_rdata`  out  32  load data.
- `o_fence_done`  out  1  single-cycle pulse when a sync completes.
- `i_ldr_req`, `i_ldr_we`  in  1  loader request, write flag.
- `i_ldr_addr`  in  14  word address.
- `i_ldr_wdata`  in  32  loader write data.
- `i_ldr_done`  in  1  single-cycle pulse; requests an IM sync.
- `o_ldr_gnt`, `o_ldr_rvalid`  out  1  loader grant, loader read data valid.
- `o_ldr_rdata`  out  32  raw word read for the loader.
- `o_dm_ren`, `o_dm_wen`  out  1  memory read / write strobe.
- `o_dm_ben`  out  4  byte enables.
- `o_dm_addr`  out  14  memory word address.
- `o_dm_wdata`  out  32  memory write data.
- `i_dm_rdata`  in  32  memory read data.
- `o_fence_i`  out  1  sync pulse to `main_mem`.
- `i_ready`  in  1  `main_mem` `o_ready`.

## Operation
- FSM states: ACCESS, FENCE, FENCE_WAIT. Reset state is ACCESS.
- **ACCESS state, grant rules.** Grants are issued only when `i_ready`=1 and no fence is pending.
  - The CPU has priority.
  - The loader wins when the CPU is not requesting, or when the starve counter equals `STARVE_LIMIT`.
  - The starve counter increments on each CPU grant while `i_ldr_req`=1. It clears on a loader grant or when `i_ldr_req`=0.
- **Handshake.** `o_*_gnt` is combinational in the request cycle. `o_dm_*` are driven combinationally from the granted request in that same cycle. A requester holds its request until it sees `gnt`.
- **Misalignment.** A request is misaligned if it is a half access with `addr[0]`=1, a word access with `addr[1:0]`≠0, or size 11. A misaligned request gets `gnt` plus `o_cpu_misaligned`, issues no memory strobe, and produces no rvalid.
- **Store formatting.**
  - Byte: wdata is `{4{wdata[7:0]}}`, ben is `1<<addr[1:0]`.
  - Half: wdata is `{2{wdata[15:0]}}`, ben is 1100 if `addr[1]` else 0011.
  - Word: ben is 1111.
  - Loader writes always use ben 1111.
  - `o_dm_addr` is `i_cpu_addr[15:2]` for the CPU and `i_ldr_addr` for the loader.
- **Load return.**
  - Owner, size, unsigned flag and `addr[1:0]` are registered at grant.
  - In the next cycle, rvalid is asserted to the owner and the data is extracted from `i_dm_rdata`: shift right by offset×8, then sign- or zero-extend.
  - The loader receives the raw word.
- **Fence requests.** `i_cpu_fence_i` or `i_ldr_done` sets a pending flag. In the next ACCESS cycle no grants are issued and the FSM moves to FENCE. A return for a read issued in the previous cycle is still delivered.
- **FENCE state.** `o_fence_i`=1 for exactly one cycle, then the FSM moves to FENCE_WAIT.
- **FENCE_WAIT state.** No grants are issued.
  - The FSM waits at least 2 cycles, then until `i_ready`=1.
  - It then pulses `o_fence_done` and returns to ACCESS.
  - Fence requests that arrive during FENCE or FENCE_WAIT re-set the pending flag, causing exactly one further sync.
  - Simultaneous CPU and loader fence pulses merge into one sync.

## Timing
- Reset values: all outputs are 0, state is ACCESS, the pending flag is clear, the starve counter is 0.
- An in-flight read is discarded on reset; no rvalid appears after reset.
- Read latency: rvalid arrives exactly 1 cycle after `gnt`. Writes complete at the grant edge.
- Throughput: one access per cycle while `i_ready`=1.
- When `i_ready`=0, `gnt` and the strobes are forced to 0. A pending return from the previous cycle is still delivered.
- Fence overhead: at least 4 cycles from the request pulse to `o_fence_done`.

## Structure
- The shared package `funrv32_pkg` holds:
  - size encodings `SZ_B`/`SZ_H`/`SZ_W`;
  - the FSM state enum;
  - owner encoding `OWN_CPU`/`OWN_LDR`.
- One sub-module, `dm_lane_fmt`: combinational store lane/ben generation and load extract/extend, instantiated once.

## Test plan
- **Byte store.** CPU SB addr 0x0006, wdata 0xAB → ben 0100, `o_dm_addr` 0x0001, wdata 0xABABABAB, `gnt` in the same cycle.
- **Signed and unsigned byte loads.** Memory word 0x80FF1234 at word 0. LB addr 3 → rdata 0xFFFFFF80, one cycle after `gnt`. LBU addr 3 → 0x00000080. LH addr 2 → 0xFFFF80FF.
- **Arbitration and starvation.** CPU and loader request continuously with `STARVE_LIMIT`=4 → CPU granted 4 cycles, loader 1, repeating. `i_ready`=0 for 3 cycles → no grants and no strobes.
- **Misalignment.** LW addr 0x0002 → `gnt` and `o_cpu_misaligned` pulse, `o_dm_ren`=0, no rvalid.
- **Fence sequencing.** `i_ldr_done` pulse, with `i_ready` low for 5 cycles after `o_fence_i` → exactly one `o_fence_i` pulse, no grants until `o_fence_done`. A second fence pulse during FENCE_WAIT → exactly one further sync.
- **Reset mid-operation.** `i_rst_n` low in the cycle after a read grant → no rvalid afterwards, all outputs 0, next access proceeds normally.

Source files
------------

// File: rtl/funrv32_pkg.sv
// Shared encodings for the data-memory path: access sizes, arbiter states and
// read-return owner tags.
package funrv32_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  typedef enum logic [1:0] {
    StAccess    = 2'd0,
    StFence     = 2'd1,
    StFenceWait = 2'd2
  } arb_state_e;

  // Size 11 has no legal encoding, so it is rejected like a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_lane_fmt.sv
// Combinational lane steering: replicates store data onto byte lanes with enables,
// and aligns/extends returned load words.
module dm_lane_fmt
  import funrv32_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_lanes,
  output logic [3:0]  st_ben,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  always_comb begin
    st_lanes = st_data;
    st_ben   = 4'b1111;
    case (st_size)
      SZ_B: begin
        st_lanes = {4{st_data[7:0]}};
        st_ben   = 4'b0001 << st_off;
      end
      SZ_H: begin
        st_lanes = {2{st_data[15:0]}};
        st_ben   = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_shift = ld_word >> {ld_off, 3'b000};
    ld_data  = ld_shift;
    case (ld_size)
      SZ_B:    ld_data = {{24{~ld_unsigned & ld_shift[7]}}, ld_shift[7:0]};
      SZ_H:    ld_data = {{16{~ld_unsigned & ld_shift[15]}}, ld_shift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares main_mem's data port between the CPU LSU and the loader, formats stores,
// returns aligned loads and sequences fence_i requests into IM syncs.
module dmem_arbiter
  import funrv32_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [1:0]  i_cpu_size,
  input  logic        i_cpu_unsigned,
  input  logic [15:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic        i_cpu_fence_i,
  output logic        o_cpu_gnt,
  output logic        o_cpu_misaligned,
  output logic        o_cpu_rvalid,
  output logic [31:0] o_cpu_rdata,
  output logic        o_fence_done,
  input  logic        i_ldr_req,
  input  logic        i_ldr_we,
  input  logic [13:0] i_ldr_addr,
  input  logic [31:0] i_ldr_wdata,
  input  logic        i_ldr_done,
  output logic        o_ldr_gnt,
  output logic        o_ldr_rvalid,
  output logic [31:0] o_ldr_rdata,
  output logic        o_dm_ren,
  output logic        o_dm_wen,
  output logic [3:0]  o_dm_ben,
  output logic [13:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  input  logic [31:0] i_dm_rdata,
  output logic        o_fence_i,
  input  logic        i_ready
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  arb_state_e    state_q, state_d;
  logic          fence_pend_q, fence_pend_d;
  logic          wait_q, wait_d;
  logic [CntW-1:0] starve_q, starve_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_own_q;
  logic [1:0]    rd_size_q;
  logic          rd_uns_q;
  logic [1:0]    rd_off_q;

  logic        live;
  logic        fence_req;
  logic        grant_ok;
  logic        fence_pulse;
  logic        done_pulse;
  logic        starve_hit;
  logic        cpu_gnt;
  logic        ldr_gnt;
  logic        cpu_mis;
  logic        cpu_acc;
  logic [31:0] st_lanes;
  logic [3:0]  st_ben;
  logic [31:0] ld_data;

  // Outputs are held quiet for the whole reset cycle, including a stale read return.
  assign live      = i_rst_n;
  assign fence_req = i_cpu_fence_i | i_ldr_done;

  always_comb begin
    state_d      = state_q;
    fence_pend_d = fence_pend_q | fence_req;
    wait_d       = wait_q;
    grant_ok     = 1'b0;
    fence_pulse  = 1'b0;
    done_pulse   = 1'b0;
    unique case (state_q)
      StAccess: begin
        if (fence_pend_q) begin
          // A request landing in this cycle is covered by the sync about to start.
          fence_pend_d = 1'b0;
          state_d      = StFence;
        end else begin
          grant_ok = i_ready;
        end
      end
      StFence: begin
        fence_pulse = 1'b1;
        wait_d      = 1'b0;
        state_d     = StFenceWait;
      end
      StFenceWait: begin
        wait_d = 1'b1;
        if (wait_q && i_ready) begin
          done_pulse = 1'b1;
          state_d    = StAccess;
        end
      end
      default: state_d = StAccess;
    endcase
  end

  assign starve_hit = (starve_q == StarveMax);
  assign cpu_gnt    = live & grant_ok & i_cpu_req & ~(i_ldr_req & starve_hit);
  assign ldr_gnt    = live & grant_ok & i_ldr_req & (~i_cpu_req | starve_hit);
  assign cpu_mis    = is_misaligned(i_cpu_size, i_cpu_addr[1:0]);
  assign cpu_acc    = cpu_gnt & ~cpu_mis;

  always_comb begin
    starve_d = starve_q;
    if (!i_ldr_req || ldr_gnt) begin
      starve_d = '0;
    end else if (cpu_gnt && !starve_hit) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  assign rd_pend_d = (cpu_acc & ~i_cpu_we) | (ldr_gnt & ~i_ldr_we);

  dm_lane_fmt u_lane_fmt (
    .st_size     (i_cpu_size),
    .st_off      (i_cpu_addr[1:0]),
    .st_data     (i_cpu_wdata),
    .st_lanes    (st_lanes),
    .st_ben      (st_ben),
    .ld_size     (rd_size_q),
    .ld_unsigned (rd_uns_q),
    .ld_off      (rd_off_q),
    .ld_word     (i_dm_rdata),
    .ld_data     (ld_data)
  );

  always_comb begin
    o_dm_ren   = 1'b0;
    o_dm_wen   = 1'b0;
    o_dm_ben   = 4'b0000;
    o_dm_addr  = '0;
    o_dm_wdata = '0;
    if (cpu_acc) begin
      o_dm_ren   = ~i_cpu_we;
      o_dm_wen   = i_cpu_we;
      o_dm_ben   = st_ben;
      o_dm_addr  = i_cpu_addr[15:2];
      o_dm_wdata = i_cpu_we ? st_lanes : '0;
    end else if (ldr_gnt) begin
      o_dm_ren   = ~i_ldr_we;
      o_dm_wen   = i_ldr_we;
      o_dm_ben   = 4'b1111;
      o_dm_addr  = i_ldr_addr;
      o_dm_wdata = i_ldr_we ? i_ldr_wdata : '0;
    end
  end

  assign o_cpu_gnt        = cpu_gnt;
  assign o_ldr_gnt        = ldr_gnt;
  assign o_cpu_misaligned = cpu_gnt & cpu_mis;
  assign o_fence_i        = live & fence_pulse;
  assign o_fence_done     = live & done_pulse;
  assign o_cpu_rvalid     = live & rd_pend_q & (rd_own_q == OWN_CPU);
  assign o_ldr_rvalid     = live & rd_pend_q & (rd_own_q == OWN_LDR);
  assign o_cpu_rdata      = o_cpu_rvalid ? ld_data : '0;
  assign o_ldr_rdata      = o_ldr_rvalid ? i_dm_rdata : '0;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= StAccess;
      fence_pend_q <= 1'b0;
      wait_q       <= 1'b0;
      starve_q     <= '0;
      rd_pend_q    <= 1'b0;
      rd_own_q     <= OWN_CPU;
      rd_size_q    <= SZ_B;
      rd_uns_q     <= 1'b0;
      rd_off_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      fence_pend_q <= fence_pend_d;
      wait_q       <= wait_d;
      starve_q     <= starve_d;
      rd_pend_q    <= rd_pend_d;
      if (cpu_acc || ldr_gnt) begin
        rd_own_q  <= cpu_acc ? OWN_CPU : OWN_LDR;
        rd_size_q <= i_cpu_size;
        rd_uns_q  <= i_cpu_unsigned;
        rd_off_q  <= i_cpu_addr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stores, loads, arbitration, misalignment,
// fence sequencing and reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_unsigned, cpu_fence_i;
  logic [1:0]  cpu_size;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt, cpu_misaligned, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        fence_done;
  logic        ldr_req, ldr_we, ldr_done;
  logic [13:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_gnt, ldr_rvalid;
  logic [31:0] ldr_rdata;
  logic        dm_ren, dm_wen;
  logic [3:0]  dm_ben;
  logic [13:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        fence_i;
  logic        ready;

  logic [12:0] ctl_out;
  logic [31:0] data_out;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned fence_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_cpu_req        (cpu_req),
    .i_cpu_we         (cpu_we),
    .i_cpu_size       (cpu_size),
    .i_cpu_unsigned   (cpu_unsigned),
    .i_cpu_addr       (cpu_addr),
    .i_cpu_wdata      (cpu_wdata),
    .i_cpu_fence_i    (cpu_fence_i),
    .o_cpu_gnt        (cpu_gnt),
    .o_cpu_misaligned (cpu_misaligned),
    .o_cpu_rvalid     (cpu_rvalid),
    .o_cpu_rdata      (cpu_rdata),
    .o_fence_done     (fence_done),
    .i_ldr_req        (ldr_req),
    .i_ldr_we         (ldr_we),
    .i_ldr_addr       (ldr_addr),
    .i_ldr_wdata      (ldr_wdata),
    .i_ldr_done       (ldr_done),
    .o_ldr_gnt        (ldr_gnt),
    .o_ldr_rvalid     (ldr_rvalid),
    .o_ldr_rdata      (ldr_rdata),
    .o_dm_ren         (dm_ren),
    .o_dm_wen         (dm_wen),
    .o_dm_ben         (dm_ben),
    .o_dm_addr        (dm_addr),
    .o_dm_wdata       (dm_wdata),
    .i_dm_rdata       (dm_rdata),
    .o_fence_i        (fence_i),
    .i_ready          (ready)
  );

  assign ctl_out  = {cpu_gnt, cpu_misaligned, cpu_rvalid, fence_done, ldr_gnt, ldr_rvalid,
                     dm_ren, dm_wen, dm_ben, fence_i};
  assign data_out = cpu_rdata | ldr_rdata | dm_wdata | {18'b0, dm_addr};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [1:0] size,
                           input logic uns, input logic [15:0] addr, input logic [31:0] wdata);
    cpu_req      = req;
    cpu_we       = we;
    cpu_size     = size;
    cpu_unsigned = uns;
    cpu_addr     = addr;
    cpu_wdata    = wdata;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 32'h0);
    cpu_fence_i = 1'b0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0; ldr_done = 1'b0;
    dm_rdata = '0;
    ready = 1'b1;

    // Reset state
    repeat (2) next_cyc();
    settle();
    check_eq("rst_ctl", 32'(ctl_out), 32'h0);
    check_eq("rst_data", data_out, 32'h0);
    next_cyc();
    rst_n = 1'b1;
    settle();
    check_eq("idle_ctl", 32'(ctl_out), 32'h0);

    // Byte store
    next_cyc();
    cpu_drive(1'b1, 1'b1, 2'b00, 1'b0, 16'h0006, 32'h0000_00AB);
    settle();
    check_eq("sb_gnt", 32'(cpu_gnt), 32'h1);
    check_eq("sb_wen", 32'(dm_wen), 32'h1);
    check_eq("sb_ren", 32'(dm_ren), 32'h0);
    check_eq("sb_ben", 32'(dm_ben), 32'h4);
    check_eq("sb_addr", 32'(dm_addr), 32'h1);
    check_eq("sb_wdata", dm_wdata, 32'hABAB_ABAB);

    // Loads, back to back
    next_cyc();
    dm_rdata = 32'h80FF_1234;
    cpu_drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0003, 32'h0);
    settle();
    check_eq("lb_gnt", 32'(cpu_gnt), 32'h1);
    check_eq("lb_ren", 32'(dm_ren), 32'h1);
    check_eq("lb_early_rv", 32'(cpu_rvalid), 32'h0);
    next_cyc();
    cpu_drive(1'b1, 1'b0, 2'b00, 1'b1, 16'h0003, 32'h0);
    settle();
    check_eq("lb_rv", 32'(cpu_rvalid), 32'h1);
    check_eq("lb_data", cpu_rdata, 32'hFFFF_FF80);
    check_eq("lbu_gnt", 32'(cpu_gnt), 32'h1);
    next_cyc();
    cpu_drive(1'b1, 1'b0, 2'b01, 1'b0, 16'h0002, 32'h0);
    settle();
    check_eq("lbu_rv", 32'(cpu_rvalid), 32'h1);
    check_eq("lbu_data", cpu_rdata, 32'h0000_0080);
    next_cyc();
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 32'h0);
    settle();
    check_eq("lh_rv", 32'(cpu_rvalid), 32'h1);
    check_eq("lh_data", cpu_rdata, 32'hFFFF_80FF);
    next_cyc();
    settle();
    check_eq("load_idle_rv", 32'(cpu_rvalid), 32'h0);

    // Arbitration: 4 CPU grants then 1 loader grant
    next_cyc();
    cpu_drive(1'b1, 1'b0, 2'b10, 1'b0, 16'h0000, 32'h0);
    ldr_req  = 1'b1;
    ldr_we   = 1'b0;
    ldr_addr = 14'd5;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) next_cyc();
      settle();
      check_eq($sformatf("arb_cpu%0d", i), 32'(cpu_gnt), 32'((i % 5) != 4));
      check_eq($sformatf("arb_ldr%0d", i), 32'(ldr_gnt), 32'((i % 5) == 4));
      if (i == 4) check_eq("ldr_addr", 32'(dm_addr), 32'd5);
      if (i == 5) begin
        check_eq("ldr_rv", 32'(ldr_rvalid), 32'h1);
        check_eq("ldr_rdata", ldr_rdata, 32'h80FF_1234);
        check_eq("ldr_cpu_rv", 32'(cpu_rvalid), 32'h0);
      end
    end

    // Back-pressure
    for (int j = 0; j < 3; j++) begin
      next_cyc();
      ready = 1'b0;
      settle();
      check_eq($sformatf("bp_gnt%0d", j), 32'({cpu_gnt, ldr_gnt}), 32'h0);
      check_eq($sformatf("bp_strb%0d", j), 32'({dm_ren, dm_wen}), 32'h0);
      if (j == 0) check_eq("bp_ldr_rv", 32'(ldr_rvalid), 32'h1);
    end
    next_cyc();
    ready = 1'b1;
    settle();
    check_eq("bp_resume", 32'({cpu_gnt, ldr_gnt}), 32'h2);

    // Misaligned word load
    next_cyc();
    ldr_req = 1'b0;
    cpu_drive(1'b1, 1'b0, 2'b10, 1'b0, 16'h0002, 32'h0);
    settle();
    check_eq("mis_gnt", 32'(cpu_gnt), 32'h1);
    check_eq("mis_flag", 32'(cpu_misaligned), 32'h1);
    check_eq("mis_ren", 32'(dm_ren), 32'h0);
    next_cyc();
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 32'h0);
    settle();
    check_eq("mis_rv", 32'(cpu_rvalid), 32'h0);
    check_eq("mis_flag_off", 32'(cpu_misaligned), 32'h0);

    // Fence: loader done, ready low 5 cycles after fence_i, second request mid-wait
    for (int k = 0; k < 14; k++) begin
      next_cyc();
      ldr_done    = (k == 0);
      cpu_fence_i = (k == 5);
      ready       = !(k >= 3 && k <= 7);
      cpu_drive(k >= 1, 1'b0, 2'b10, 1'b0, 16'h0004, 32'h0);
      settle();
      if (fence_i) fence_cnt++;
      check_eq($sformatf("fc_gnt%0d", k), 32'(cpu_gnt), 32'(k == 13));
      check_eq($sformatf("fc_fi%0d", k), 32'(fence_i), 32'(k == 2 || k == 10));
      check_eq($sformatf("fc_done%0d", k), 32'(fence_done), 32'(k == 8 || k == 12));
    end
    check_eq("fc_count", 32'(fence_cnt), 32'd2);
    next_cyc();
    cpu_fence_i = 1'b0;
    ldr_done    = 1'b0;
    ready       = 1'b1;
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 32'h0);

    // Reset right after a read grant
    next_cyc();
    cpu_drive(1'b1, 1'b0, 2'b10, 1'b0, 16'h0000, 32'h0);
    settle();
    check_eq("rr_gnt", 32'(cpu_gnt), 32'h1);
    next_cyc();
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 32'h0);
    rst_n = 1'b0;
    settle();
    check_eq("rr_ctl", 32'(ctl_out), 32'h0);
    check_eq("rr_data", data_out, 32'h0);
    next_cyc();
    rst_n = 1'b1;
    settle();
    check_eq("rr_post_ctl", 32'(ctl_out), 32'h0);
    next_cyc();
    cpu_drive(1'b1, 1'b0, 2'b10, 1'b0, 16'h0004, 32'h0);
    settle();
    check_eq("rr_next_gnt", 32'(cpu_gnt), 32'h1);
    check_eq("rr_next_addr", 32'(dm_addr), 32'h1);
    next_cyc();
    cpu_drive(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 32'h0);
    settle();
    check_eq("rr_next_rv", 32'(cpu_rvalid), 32'h1);
    check_eq("rr_next_data", cpu_rdata, 32'h80FF_1234);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
